// File: rtl/cluster_mem_responder_if.sv
// Cluster request / DRAM controller bundle for cluster_mem_responder.
// master = cluster plus DRAM controller side, slave = the responder.
interface cluster_mem_responder_if;
   logic         w_req;
   logic         w_req_iscode;
   logic         w_req_we;
   logic [31:0]  w_req_addr;
   logic [2:0]   w_req_ctrl;
   logic [31:0]  w_req_wdata;
   logic         w_busy;
   logic [127:0] w_insn_data;
   logic [127:0] w_data_data;
   logic         w_is_dram_data;
   logic         w_misalign;
   logic         w_err;
   logic         w_dram_req;
   logic         w_dram_we;
   logic [31:0]  w_dram_addr;
   logic [31:0]  w_dram_wdata;
   logic [3:0]   w_dram_be;
   logic         w_dram_ack;
   logic [127:0] w_dram_rdata;

   modport master (
      output w_req, w_req_iscode, w_req_we, w_req_addr, w_req_ctrl, w_req_wdata,
      output w_dram_ack, w_dram_rdata,
      input  w_busy, w_insn_data, w_data_data, w_is_dram_data, w_misalign, w_err,
      input  w_dram_req, w_dram_we, w_dram_addr, w_dram_wdata, w_dram_be
   );

   modport slave (
      input  w_req, w_req_iscode, w_req_we, w_req_addr, w_req_ctrl, w_req_wdata,
      input  w_dram_ack, w_dram_rdata,
      output w_busy, w_insn_data, w_data_data, w_is_dram_data, w_misalign, w_err,
      output w_dram_req, w_dram_we, w_dram_addr, w_dram_wdata, w_dram_be
   );
endinterface

// File: rtl/cluster_mem_responder.sv
// Shared-memory responder: one cluster request at a time, served by a line-based DRAM controller.
// Build macro RESP_TIMEOUT_EN adds a watchdog that aborts a stalled downstream access with w_err.
module cluster_mem_responder #(
   parameter logic [3:0] MEM_BASE_TADDR = 4'h8,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic                     CLK,
   input  logic                     RST_X,
   cluster_mem_responder_if.slave   bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t         state_r;
   logic           iscode_r;
   logic           busy_r;
   logic [127:0]   insn_data_r;
   logic [127:0]   data_data_r;
   logic           is_dram_r;
   logic           misalign_r;
   logic           err_r;
   logic           dram_req_r;
   logic           dram_we_r;
   logic [31:0]    dram_addr_r;
   logic [31:0]    dram_wdata_r;
   logic [3:0]     dram_be_r;

   logic           st_ok_s;
   logic [3:0]     st_be_s;
   logic [31:0]    st_data_s;
   logic           timeout_s;
   logic           unused_s;

   // Store size decode: alignment legality, lane enables and lane-replicated data.
   always_comb begin
      st_ok_s   = 1'b0;
      st_be_s   = 4'b0000;
      st_data_s = 32'h0000_0000;
      case (bus.w_req_ctrl[1:0])
         2'b00: begin
            st_ok_s   = 1'b1;
            st_be_s   = 4'b0001 << bus.w_req_addr[1:0];
            st_data_s = {4{bus.w_req_wdata[7:0]}};
         end
         2'b01: begin
            st_ok_s   = ~bus.w_req_addr[0];
            st_be_s   = 4'b0011 << bus.w_req_addr[1:0];
            st_data_s = {2{bus.w_req_wdata[15:0]}};
         end
         2'b10: begin
            st_ok_s   = (bus.w_req_addr[1:0] == 2'b00);
            st_be_s   = 4'b1111;
            st_data_s = bus.w_req_wdata;
         end
         default: begin
            st_ok_s   = 1'b0;
            st_be_s   = 4'b0000;
            st_data_s = 32'h0000_0000;
         end
      endcase
   end

`ifdef RESP_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_r;

   assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

   // Watchdog: counts wait cycles without an ack, cleared whenever the FSM is not waiting.
   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         cnt_r <= '0;
      end else if ((state_r == RD_WAIT || state_r == WR_WAIT) && !bus.w_dram_ack && !timeout_s) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= '0;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Read width is irrelevant: the whole line goes back and the core extracts it.
   assign unused_s = bus.w_req_ctrl[2] ^ (TIMEOUT_CYCLES > 0);

   // Request FSM with all cluster and downstream outputs registered.
   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         state_r      <= IDLE;
         iscode_r     <= 1'b0;
         busy_r       <= 1'b0;
         insn_data_r  <= 128'h0;
         data_data_r  <= 128'h0;
         is_dram_r    <= 1'b0;
         misalign_r   <= 1'b0;
         err_r        <= 1'b0;
         dram_req_r   <= 1'b0;
         dram_we_r    <= 1'b0;
         dram_addr_r  <= 32'h0;
         dram_wdata_r <= 32'h0;
         dram_be_r    <= 4'b0000;
      end else begin
         misalign_r <= 1'b0;
         err_r      <= 1'b0;
         case (state_r)
            IDLE: begin
               busy_r <= bus.w_req;
               if (bus.w_req) begin
                  iscode_r <= bus.w_req_iscode;
                  if (bus.w_req_addr[31:28] != MEM_BASE_TADDR) begin
                     is_dram_r <= 1'b0;
                     state_r   <= DONE;
                  end else if (bus.w_req_iscode || !bus.w_req_we) begin
                     dram_req_r  <= 1'b1;
                     dram_we_r   <= 1'b0;
                     dram_addr_r <= {bus.w_req_addr[31:4], 4'h0};
                     state_r     <= RD_WAIT;
                  end else if (st_ok_s) begin
                     dram_req_r   <= 1'b1;
                     dram_we_r    <= 1'b1;
                     dram_addr_r  <= {bus.w_req_addr[31:2], 2'b00};
                     dram_wdata_r <= st_data_s;
                     dram_be_r    <= st_be_s;
                     state_r      <= WR_WAIT;
                  end else begin
                     misalign_r <= 1'b1;
                     state_r    <= DONE;
                  end
               end
            end
            RD_WAIT: begin
               busy_r <= 1'b1;
               if (bus.w_dram_ack) begin
                  dram_req_r <= 1'b0;
                  if (iscode_r) insn_data_r <= bus.w_dram_rdata;
                  else          data_data_r <= bus.w_dram_rdata;
                  is_dram_r  <= 1'b1;
                  state_r    <= DONE;
               end else if (timeout_s) begin
                  dram_req_r <= 1'b0;
                  err_r      <= 1'b1;
                  if (iscode_r) insn_data_r <= {128{1'b1}};
                  else          data_data_r <= {128{1'b1}};
                  state_r    <= DONE;
               end
            end
            WR_WAIT: begin
               busy_r <= 1'b1;
               if (bus.w_dram_ack) begin
                  dram_req_r <= 1'b0;
                  state_r    <= DONE;
               end else if (timeout_s) begin
                  dram_req_r <= 1'b0;
                  err_r      <= 1'b1;
                  state_r    <= DONE;
               end
            end
            DONE: begin
               busy_r  <= 1'b1;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.w_busy         = busy_r;
   assign bus.w_insn_data    = insn_data_r;
   assign bus.w_data_data    = data_data_r;
   assign bus.w_is_dram_data = is_dram_r;
   assign bus.w_misalign     = misalign_r;
   assign bus.w_err          = err_r;
   assign bus.w_dram_req     = dram_req_r;
   assign bus.w_dram_we      = dram_we_r;
   assign bus.w_dram_addr    = dram_addr_r;
   assign bus.w_dram_wdata   = dram_wdata_r;
   assign bus.w_dram_be      = dram_be_r;
endmodule

// File: tb/tb_cluster_mem_responder.sv
// Directed bench for cluster_mem_responder: reads, stores, misalignment, device space, reset, watchdog.
module tb_cluster_mem_responder;
   localparam int TB_TIMEOUT = 8;
   localparam logic [127:0] LINE_I = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] LINE_D = 128'hDEADBEEF_00112233_44556677_8899AABB;
   localparam logic [127:0] LINE_J = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

   logic CLK;
   logic RST_X;
   int   n_checks;
   int   n_pass;
   int   busy_cnt;

   cluster_mem_responder_if bus();

   cluster_mem_responder #(
      .MEM_BASE_TADDR(4'h8),
      .TIMEOUT_CYCLES(TB_TIMEOUT)
   ) dut (
      .CLK   (CLK),
      .RST_X (RST_X),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic iscode, input logic we, input logic [31:0] addr,
                        input logic [2:0] ctrl, input logic [31:0] wdata);
      bus.w_req        = 1'b1;
      bus.w_req_iscode = iscode;
      bus.w_req_we     = we;
      bus.w_req_addr   = addr;
      bus.w_req_ctrl   = ctrl;
      bus.w_req_wdata  = wdata;
      tick();
      bus.w_req        = 1'b0;
   endtask

   task automatic ack_line(input logic [127:0] line);
      bus.w_dram_ack   = 1'b1;
      bus.w_dram_rdata = line;
      tick();
      bus.w_dram_ack   = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 10 && bus.w_busy; i++) tick();
      check(tag, bus.w_busy, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      RST_X = 1'b0;
      bus.w_req = 1'b0; bus.w_req_iscode = 1'b0; bus.w_req_we = 1'b0;
      bus.w_req_addr = 32'h0; bus.w_req_ctrl = 3'b000; bus.w_req_wdata = 32'h0;
      bus.w_dram_ack = 1'b0; bus.w_dram_rdata = 128'h0;
      tick(); tick();
      check("rst_busy", bus.w_busy, 1'b0);
      check("rst_insn", bus.w_insn_data, 128'h0);
      check("rst_data", bus.w_data_data, 128'h0);
      check("rst_isdram", bus.w_is_dram_data, 1'b0);
      check("rst_req", bus.w_dram_req, 1'b0);
      check("rst_addr", bus.w_dram_addr, 32'h0);
      check("rst_be", bus.w_dram_be, 4'b0000);
      check("rst_err", bus.w_err, 1'b0);
      RST_X = 1'b1;
      tick();

      // Instruction fetch: 3 wait cycles, then ack; busy spans 5 cycles
      issue(1'b1, 1'b0, 32'h8000_1234, 3'b010, 32'h0);
      check("fetch_req", bus.w_dram_req, 1'b1);
      check("fetch_we", bus.w_dram_we, 1'b0);
      check("fetch_addr", bus.w_dram_addr, 32'h8000_1230);
      busy_cnt = bus.w_busy ? 1 : 0;
      tick(); busy_cnt += bus.w_busy ? 1 : 0;
      tick(); busy_cnt += bus.w_busy ? 1 : 0;
      ack_line(LINE_I);
      busy_cnt += bus.w_busy ? 1 : 0;
      check("fetch_req_drop", bus.w_dram_req, 1'b0);
      check("fetch_insn", bus.w_insn_data, LINE_I);
      check("fetch_data_keep", bus.w_data_data, 128'h0);
      check("fetch_isdram", bus.w_is_dram_data, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick();
         busy_cnt += bus.w_busy ? 1 : 0;
      end
      check("fetch_busy_cycles", busy_cnt, 5);

      // Data load goes to the data register only
      issue(1'b0, 1'b0, 32'h8000_0044, 3'b100, 32'h0);
      check("load_addr", bus.w_dram_addr, 32'h8000_0040);
      ack_line(LINE_D);
      check("load_data", bus.w_data_data, LINE_D);
      check("load_insn_keep", bus.w_insn_data, LINE_I);
      wait_idle("load_idle");

      // Byte store to lane 3; busy released 2 cycles after the ack
      issue(1'b0, 1'b1, 32'h8000_0003, 3'b000, 32'h0000_00AB);
      check("sb_req", bus.w_dram_req, 1'b1);
      check("sb_we", bus.w_dram_we, 1'b1);
      check("sb_addr", bus.w_dram_addr, 32'h8000_0000);
      check("sb_be", bus.w_dram_be, 4'b1000);
      check("sb_lane", bus.w_dram_wdata[31:24], 8'hAB);
      ack_line(LINE_J);
      check("sb_req_drop", bus.w_dram_req, 1'b0);
      check("sb_busy_ack", bus.w_busy, 1'b1);
      tick();
      check("sb_busy_ack1", bus.w_busy, 1'b1);
      tick();
      check("sb_busy_ack2", bus.w_busy, 1'b0);
      check("sb_data_keep", bus.w_data_data, LINE_D);

      // Halfword store to upper half, word store
      issue(1'b0, 1'b1, 32'h8000_0006, 3'b001, 32'h0000_1234);
      check("sh_addr", bus.w_dram_addr, 32'h8000_0004);
      check("sh_be", bus.w_dram_be, 4'b1100);
      check("sh_lane", bus.w_dram_wdata[31:16], 16'h1234);
      ack_line(LINE_J);
      wait_idle("sh_idle");
      issue(1'b0, 1'b1, 32'h8000_0008, 3'b010, 32'hCAFE_F00D);
      check("sw_addr", bus.w_dram_addr, 32'h8000_0008);
      check("sw_be", bus.w_dram_be, 4'b1111);
      check("sw_wdata", bus.w_dram_wdata, 32'hCAFE_F00D);
      ack_line(LINE_J);
      wait_idle("sw_idle");

      // Misaligned word store: pulse, no downstream access, busy 2 cycles
      issue(1'b0, 1'b1, 32'h8000_0002, 3'b010, 32'h1111_2222);
      check("mis_pulse", bus.w_misalign, 1'b1);
      check("mis_req", bus.w_dram_req, 1'b0);
      check("mis_busy0", bus.w_busy, 1'b1);
      tick();
      check("mis_pulse_end", bus.w_misalign, 1'b0);
      check("mis_req1", bus.w_dram_req, 1'b0);
      check("mis_busy1", bus.w_busy, 1'b1);
      tick();
      check("mis_busy2", bus.w_busy, 1'b0);
      issue(1'b0, 1'b1, 32'h8000_0001, 3'b001, 32'h0);
      check("mis_sh_pulse", bus.w_misalign, 1'b1);
      check("mis_sh_req", bus.w_dram_req, 1'b0);
      wait_idle("mis_sh_idle");

      // Device-space load: no downstream request, data untouched
      issue(1'b0, 1'b0, 32'h1000_0000, 3'b010, 32'h0);
      check("dev_req", bus.w_dram_req, 1'b0);
      check("dev_isdram", bus.w_is_dram_data, 1'b0);
      check("dev_busy", bus.w_busy, 1'b1);
      wait_idle("dev_idle");
      check("dev_data_keep", bus.w_data_data, LINE_D);

      // Request during RD_WAIT ignored; stray ack in IDLE ignored
      issue(1'b0, 1'b0, 32'h8000_0100, 3'b010, 32'h0);
      issue(1'b0, 1'b1, 32'h8000_0204, 3'b010, 32'h5555_5555);
      check("ign_addr", bus.w_dram_addr, 32'h8000_0100);
      check("ign_we", bus.w_dram_we, 1'b0);
      ack_line(LINE_J);
      check("ign_data", bus.w_data_data, LINE_J);
      wait_idle("ign_idle");
      check("ign_no_req", bus.w_dram_req, 1'b0);
      ack_line(LINE_I);
      check("stray_ack_data", bus.w_data_data, LINE_J);
      check("stray_ack_busy", bus.w_busy, 1'b0);

      // Reset in RD_WAIT abandons the access; a late ack changes nothing
      issue(1'b1, 1'b0, 32'h8000_0300, 3'b010, 32'h0);
      check("rw_req", bus.w_dram_req, 1'b1);
      RST_X = 1'b0;
      tick();
      RST_X = 1'b1;
      check("rw_req_drop", bus.w_dram_req, 1'b0);
      check("rw_busy", bus.w_busy, 1'b0);
      ack_line(LINE_D);
      check("rw_late_insn", bus.w_insn_data, 128'h0);
      check("rw_late_data", bus.w_data_data, 128'h0);
      check("rw_late_busy", bus.w_busy, 1'b0);
      issue(1'b0, 1'b0, 32'h8000_0400, 3'b010, 32'h0);
      check("rw_idle_accept", bus.w_dram_addr, 32'h8000_0400);

`ifdef RESP_TIMEOUT_EN
      // Watchdog: no ack for TB_TIMEOUT cycles
      for (int i = 1; i < TB_TIMEOUT; i++) tick();
      check("to_err_early", bus.w_err, 1'b0);
      check("to_req_held", bus.w_dram_req, 1'b1);
      tick();
      check("to_err", bus.w_err, 1'b1);
      check("to_req_drop", bus.w_dram_req, 1'b0);
      check("to_data_ones", bus.w_data_data, {128{1'b1}});
      tick();
      check("to_err_pulse", bus.w_err, 1'b0);
      wait_idle("to_idle");
`else
      // Without the watchdog the responder waits indefinitely
      for (int i = 0; i < 20; i++) tick();
      check("wait_err", bus.w_err, 1'b0);
      check("wait_req_held", bus.w_dram_req, 1'b1);
      check("wait_busy", bus.w_busy, 1'b1);
      ack_line(LINE_I);
      check("wait_data", bus.w_data_data, LINE_I);
      wait_idle("wait_idle");
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
